// File: rtl/mul_pkg.sv
// Shared constants and payload types for the multiply issue path.
// Both the issue/collect stage and the multiplier take their widths and
// latency from here so the tracking pipe always matches the datapath.
package mul_pkg;

  localparam int unsigned W              = 4;      // operand width
  localparam int unsigned TAG_W          = 2;      // opaque tag width
  localparam int unsigned MUL_LAT        = 1;      // multiplier latency (>=1)
  localparam int unsigned FIFO_DEPTH_DEF = 4;      // default result FIFO depth
  localparam int unsigned PW             = 2 * W;  // product width

  // One completed operation as held in the result FIFO.
  typedef struct packed {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
  } mul_res_t;

endpackage

// File: rtl/mul_result_fifo.sv
// Synchronous result FIFO with first-word-fall-through head.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (pointers/count only)
//   clear      - synchronous discard of all entries; drops a same-cycle push
//   push, push_data - write an entry
//   pop        - consume the head entry; ignored when empty
//   head       - entry at the head (don't-care while count==0)
//   count      - number of valid entries
module mul_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;

  assign pop_ok = pop && (count != '0);

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // Storage is not reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

  // The issuer's credit scheme must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && !clear) begin
      assert (!(push && count == CNT_W'(DEPTH)));
    end
  end

endmodule

// File: rtl/multiplier_pipe.sv
// Fixed-latency unsigned array multiplier used by the execute path.
// Ports:
//   clk  - clock
//   a, b - operands (W bits)
//   p    - product (PW bits), valid MUL_LAT cycles after a/b
// Internal stages are intentionally not reset; consumers qualify p with
// their own valid tracking.
module multiplier_pipe
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p
);

  logic [PW-1:0] stage [MUL_LAT];

  // Multiply into stage 0, then delay through the remaining stages.
  always_ff @(posedge clk) begin
    stage[0] <= PW'(a) * PW'(b);
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/collect stage around the fixed-latency multiplier.
// Accepts tagged operand pairs, drives them to the multiplier, tracks them
// through a valid/tag pipe matching the multiplier latency, and returns
// products in issue order through a credit-protected result FIFO.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   flush             - synchronous discard of in-flight and queued work
//   in_valid/in_ready - request handshake; in_a, in_b, in_tag payload
//   mul_a, mul_b      - operands to the multiplier (zero when not firing)
//   mul_p             - product from the multiplier
//   out_valid/out_ready - result handshake; out_p, out_tag payload
//   busy              - work in flight or queued
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [PW-1:0]    mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned INF_W = $clog2(MUL_LAT + 1);
  localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

  logic [MUL_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [MUL_LAT];
  logic [INF_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic               fire;
  logic               push;
  logic               pop;
  mul_res_t           push_res;
  mul_res_t           head_res;

  // Credits: every in-flight op already owns a FIFO slot, so issue only
  // while queued + in-flight leaves room. Uses registered state only.
  assign in_ready = rst_n && !flush &&
                    ((CRD_W'(fifo_count) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH));
  assign fire     = in_valid && in_ready;

  // Idle cycles present zeros to the multiplier.
  assign mul_a = fire ? in_a : '0;
  assign mul_b = fire ? in_b : '0;

  // Valid bits of the tracking pipe; cleared by reset or flush so any stale
  // product still inside the multiplier is never captured.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= fire;
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Tags ride alongside the valid bits; qualified by pipe_vld only.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= in_tag;
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // In-flight count for the credit check and busy.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight = inflight + INF_W'(pipe_vld[i]);
    end
  end

  // Last pipe stage lines up with the product leaving the multiplier.
  assign push         = pipe_vld[MUL_LAT-1];
  assign push_res.p   = mul_p;
  assign push_res.tag = pipe_tag[MUL_LAT-1];
  assign pop          = out_valid && out_ready;

  mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    ($bits(mul_res_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (push_res),
    .pop       (pop),
    .head      (head_res),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_p     = head_res.p;
  assign out_tag   = head_res.tag;
  assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a transaction-level model:
// ops are queued with the cycle their product becomes available, and a
// result queue holds completed products in issue order.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int unsigned DEPTH = FIFO_DEPTH_DEF;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [PW-1:0]    mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  mul_issue_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  multiplier_pipe u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
    int               due;
  } op_t;

  op_t iq[$];   // issued, product not yet captured
  op_t fq[$];   // captured, awaiting consumer
  int  cyc;
  bit  known;
  int  checks;
  int  failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int a, input int b, input int t);
    in_valid = v;
    in_a     = W'(a);
    in_b     = W'(b);
    in_tag   = TAG_W'(t);
  endtask

  // One clock: compare outputs against the model, then advance the model.
  task automatic step();
    bit m_ready;
    bit m_fire;
    bit m_pop;
    m_ready = rst_n && !flush && ((fq.size() + iq.size()) < DEPTH);
    m_fire  = in_valid && m_ready;
    m_pop   = (fq.size() != 0) && out_ready;
    #1;
    if (known) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("out_valid", 32'(out_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
        check("out_p", 32'(out_p), 32'(fq[0].p));
        check("out_tag", 32'(out_tag), 32'(fq[0].tag));
      end
      check("busy", 32'(busy), 32'((fq.size() + iq.size()) != 0));
      check("mul_a", 32'(mul_a), m_fire ? 32'(in_a) : 32'd0);
      check("mul_b", 32'(mul_b), m_fire ? 32'(in_b) : 32'd0);
    end else if (!rst_n) begin
      check("in_ready_rst", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    if (!rst_n || flush) begin
      fq.delete();
      iq.delete();
      known = 1'b1;
    end else begin
      if (m_pop) void'(fq.pop_front());
      while (iq.size() != 0 && iq[0].due == cyc) fq.push_back(iq.pop_front());
      if (m_fire) iq.push_back('{PW'(in_a) * PW'(in_b), in_tag, cyc + int'(MUL_LAT)});
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    known    = 1'b0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    drive(1, 3, 5, 1);

    // Reset held with a pending request.
    repeat (2) step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    step();

    // Single op 9*13.
    drive(1, 9, 13, 2);
    step();
    drive(0, 0, 0, 0);
    repeat (5) step();

    // Back-to-back stream, plus the corner products.
    for (int i = 0; i < 16; i++) begin
      drive(1, i, 15 - i, i % 4);
      step();
    end
    drive(1, 15, 15, 1);
    step();
    drive(1, 0, 15, 2);
    step();
    drive(0, 0, 0, 0);
    repeat (4) step();

    // Back-pressure fills the FIFO, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, i + 3, i + 7, i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, i, i + 1, i);
      step();
    end
    drive(0, 0, 0, 0);
    repeat (4) step();

    // Flush with work in flight and queued, fire attempted in flush cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 5, 11, i);
      step();
    end
    flush = 1'b1;
    drive(1, 7, 7, 3);
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    repeat (8) step();

    // Same scenario using reset, then an op right after release.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 8, 13, i);
      step();
    end
    rst_n = 1'b0;
    drive(1, 7, 7, 3);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1, 12, 11, 1);
    step();
    drive(0, 0, 0, 0);
    repeat (8) step();

    // Randomized traffic with occasional flush/reset.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) < 70, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      out_ready = $urandom_range(0, 99) < 60;
      flush     = $urandom_range(0, 99) < 3;
      rst_n     = !($urandom_range(0, 99) < 2);
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
